seq_restoring_divider: RTL

- Iterative unsigned restoring divider; the inverse operation of the benchmark multiplier datapaths.
- Divides one BITS-wide dividend by one BITS-wide divisor and produces one quotient bit per clock.
- Uses a start/done handshake. Sits beside the multiply benchmarks as a sequential arithmetic benchmark for synthesis regression.

---
 rtl/seq_restoring_divider.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int BITS = 8,
  parameter int CW   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS:0]   r_q, r_d;      // partial remainder, one bit wider than the divisor
  logic [BITS-1:0] q_q, q_d;      // dividend shifting out, quotient shifting in
  logic [BITS-1:0] d_q, d_d;
  logic [BITS-1:0] quot_q, quot_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [BITS+1:0] shifted;
  logic [BITS+1:0] trial;
  logic            ge;
  logic [BITS:0]   r_step;
  logic [BITS-1:0] q_step;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  always_comb begin
    shifted = {r_q, q_q[BITS-1]};
    trial   = shifted - {2'b00, d_q};
    ge      = ~trial[BITS+1];
    r_step  = ge ? trial[BITS:0] : shifted[BITS:0];
    q_step  = {q_q[BITS-2:0], ge};
  end

  // Next-state logic: accept from IDLE/DONE, iterate in RUN, capture results on the last step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero skips iteration entirely
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BITS - 1)) begin
          state_d = S_DONE;
          quot_d  = q_step;
          rem_d   = r_step[BITS-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
